// File: rtl/mem_io_responder_pkg.sv
// Shared types, IO port map and address decode for the RAM/IO responder.
package mem_io_responder_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [31:0] RAM_IO_PORT   = 32'h0003_0000;
    localparam logic [31:0] RAM_HALT_PORT = 32'h0003_0004;
    localparam logic [1:0]  IO_SEL        = 2'b11;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_UART,
        ACC_HALT,
        ACC_IO_OTHER
    } access_t;

    // Classify a controller address: IO window first, then the two known ports.
    function automatic access_t decode_access(input logic [31:0] addr);
        access_t kind;
        kind = ACC_RAM;
        if (addr[17:16] == IO_SEL) begin
            if (addr == RAM_IO_PORT) begin
                kind = ACC_UART;
            end else if (addr == RAM_HALT_PORT) begin
                kind = ACC_HALT;
            end else begin
                kind = ACC_IO_OTHER;
            end
        end
        return kind;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module mem_io_responder_byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  byte_t                    push_data,
    input  logic                     pop,
    output byte_t                    head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    byte_t             mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              full;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is not reset; only slots behind the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// RAM-side responder for the byte-serial memory bus: byte RAM, IO window
// decode (UART data port, halt port) and TX/RX byte FIFOs toward the UART.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_write_flag,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_data,
    output logic [7:0]  out_data,
    output logic        out_uart_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        out_halt,
    output logic        out_overflow
);

    localparam int TX_CW = $clog2(TX_FIFO_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_FIFO_DEPTH) + 1;

    byte_t                 ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    access_t               acc;

    logic       is_write;
    logic       is_read;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_drop;
    byte_t      tx_head;
    logic [TX_CW-1:0] tx_count;
    logic [TX_CW-1:0] tx_count_next;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_drop;
    byte_t      rx_head;
    logic [RX_CW-1:0] rx_count;
    logic       rx_empty;

    assign ram_idx  = in_addr[ADDR_WIDTH-1:0];
    assign acc      = decode_access(in_addr);
    assign is_write = rdy && in_write_flag;
    assign is_read  = rdy && !in_write_flag;

    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_valid ? tx_head : 8'h00;
    assign tx_push  = is_write && (acc == ACC_UART);
    assign tx_pop   = rdy && tx_valid && tx_ready;

    assign rx_empty = (rx_count == '0);
    assign rx_push  = rdy && rx_valid;
    assign rx_pop   = is_read && (acc == ACC_UART) && !rx_empty;

    mem_io_responder_byte_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (in_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .drop      (tx_drop)
    );

    mem_io_responder_byte_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count),
        .drop      (rx_drop)
    );

    // TX occupancy after this edge, so the near-full flag tracks the count without extra lag.
    always_comb begin
        tx_count_next = tx_count;
        if (tx_push && !tx_drop && !tx_pop) begin
            tx_count_next = tx_count + 1'b1;
        end else if (!(tx_push && !tx_drop) && tx_pop) begin
            tx_count_next = tx_count - 1'b1;
        end
    end

    // RAM byte write; the array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (is_write && (acc == ACC_RAM)) begin
            ram[ram_idx] <= in_data;
        end
    end

    // Read data register: RAM is read-first, UART pops RX head, other IO reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= 8'h00;
        end else if (is_read) begin
            case (acc)
                ACC_RAM:  out_data <= ram[ram_idx];
                ACC_UART: out_data <= rx_empty ? 8'h00 : rx_head;
                default:  out_data <= 8'h00;
            endcase
        end
    end

    // Near-full keeps two slots of headroom for writes the controller has already issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_uart_full <= 1'b0;
        end else if (rdy) begin
            out_uart_full <= (tx_count_next >= TX_CW'(TX_FIFO_DEPTH - 2));
        end
    end

    // Sticky halt and overflow flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_halt     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            if (is_write && (acc == ACC_HALT)) begin
                out_halt <= 1'b1;
            end
            if (tx_drop || rx_drop) begin
                out_overflow <= 1'b1;
            end
        end
    end

endmodule
